// File: rtl/cordic_mult_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : cordic_mult_dispatch
// Description : Operand-side front end for the CORDIC approximate multiplier.
//               Buffers signed (x,z) pairs in a small FIFO, issues them one at
//               a time over a start/done handshake, and returns each product
//               (or a timeout abort) on a valid/ready result stream.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_mult_dispatch #(
    parameter int W          = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*W-1:0]   res_y,
    output logic             res_err,
    output logic             mul_start,
    output logic [W-1:0]     mul_x,
    output logic [W-1:0]     mul_z,
    input  logic [2*W-1:0]   mul_y,
    input  logic             mul_done,
    output logic             busy,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_tmr_w  = $clog2(TIMEOUT);

    localparam logic [c_addr_w:0]  c_depth    = FIFO_DEPTH[c_addr_w:0];
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_recover = 3'd1;
    localparam logic [2:0] c_st_issue   = 3'd2;
    localparam logic [2:0] c_st_wait    = 3'd3;
    localparam logic [2:0] c_st_hold    = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;

    logic [2*W-1:0]      r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;

    logic [W-1:0]        r_mul_x;
    logic [W-1:0]        r_mul_z;
    logic [2*W-1:0]      r_res_y;
    logic                r_res_err;
    logic [c_tmr_w-1:0]  r_timer;
    logic [CNT_W-1:0]    r_issued;

    logic                w_push;
    logic                w_pop;
    logic                w_nonempty;

    // Occupancy is registered, so a pair written this cycle is only visible
    // to the IDLE pop on the following cycle (no push-through).
    assign w_nonempty = (r_count != '0);
    assign in_ready   = (r_count != c_depth);
    assign w_push     = in_valid & in_ready;
    assign w_pop      = (r_state == c_st_idle) & w_nonempty;

    // FIFO storage: write the packed {x,z} pair at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_x, in_z};
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a done still high from an earlier job (or from
    // before a reset) is drained in RECOVER so it cannot complete the new job.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_nonempty) begin
                    w_next_state = mul_done ? c_st_recover : c_st_issue;
                end
            end
            c_st_recover: begin
                if (!mul_done) begin
                    w_next_state = c_st_issue;
                end
            end
            c_st_issue: begin
                w_next_state = c_st_wait;
            end
            c_st_wait: begin
                if (mul_done || (r_timer == c_tmr_last)) begin
                    w_next_state = c_st_hold;
                end
            end
            c_st_hold: begin
                if (res_ready) begin
                    w_next_state = c_st_idle;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Datapath: operand latch on pop, job counter/timer, result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_x   <= '0;
            r_mul_z   <= '0;
            r_res_y   <= '0;
            r_res_err <= 1'b0;
            r_timer   <= '0;
            r_issued  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_nonempty) begin
                        r_mul_x <= r_mem[r_rd_ptr][2*W-1:W];
                        r_mul_z <= r_mem[r_rd_ptr][W-1:0];
                    end
                end
                c_st_issue: begin
                    r_issued <= r_issued + 1'b1;
                    r_timer  <= '0;
                end
                c_st_wait: begin
                    if (mul_done) begin
                        r_res_y   <= mul_y;
                        r_res_err <= 1'b0;
                    end else if (r_timer == c_tmr_last) begin
                        r_res_y   <= '0;
                        r_res_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mul_start  = (r_state == c_st_issue);
    assign res_valid  = (r_state == c_st_hold);
    assign mul_x      = r_mul_x;
    assign mul_z      = r_mul_z;
    assign res_y      = r_res_y;
    assign res_err    = r_res_err;
    assign issued_cnt = r_issued;
    assign busy       = (r_state != c_st_idle) | w_nonempty;

endmodule
`default_nettype wire
